// File: rtl/x_multdiv.sv
// x_multdiv: iterative signed mul/div unit, 32-cycle shift-add multiply and restoring divide on magnitudes.
// Define X_MULTDIV_DIVZERO_FAST_EN to finish a divide-by-zero after a single BUSY cycle.
module x_multdiv (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] in_IR,
  input  logic [31:0] data_in_A,
  input  logic [31:0] data_in_B,
  output logic        stall,
  output logic [31:0] result,
  output logic        result_valid,
  output logic        exception,
  output logic [4:0]  result_rd
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state;
  logic [5:0] cnt;
  logic [63:0] p, p_nxt, pm;
  logic [31:0] mc, fin_res;
  logic [32:0] sum, diff;
  logic [64:0] sh;
  logic [4:0] rd;
  logic is_div, neg, b_zero, last, fin_exc, dec_md, dec_div;
  function automatic logic [31:0] mag(input logic [31:0] v);
    return v[31] ? -v : v;
  endfunction
  assign dec_md = in_IR[31:27] == 5'd0 && in_IR[6:3] == 4'b0011;
  assign dec_div = in_IR[2];
  assign stall = reset && dec_md && state != DONE;
`ifdef X_MULTDIV_DIVZERO_FAST_EN
  assign last = cnt == 6'd31 || (is_div && b_zero);
`else
  assign last = cnt == 6'd31;
`endif
  // p holds {partial product, multiplier} for mul and {remainder, dividend/quotient} for div
  always_comb begin
    sum = {1'b0, p[63:32]} + (p[0] ? {1'b0, mc} : 33'd0);
    sh = {p, 1'b0};
    diff = sh[64:32] - {1'b0, mc};
    p_nxt = is_div ? (diff[32] ? sh[63:0] : {diff[31:0], sh[31:1], 1'b1}) : {sum, p[31:1]};
    pm = neg ? -p_nxt : p_nxt;
    fin_res = (is_div && b_zero) ? 32'd0 : pm[31:0];
    fin_exc = is_div ? (b_zero || (!neg && p_nxt[31])) : pm[63:32] != {32{pm[31]}};
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt <= 6'd0;
      p <= 64'd0;
      mc <= 32'd0;
      rd <= 5'd0;
      is_div <= 1'b0;
      neg <= 1'b0;
      b_zero <= 1'b0;
      result <= 32'd0;
      result_valid <= 1'b0;
      exception <= 1'b0;
      result_rd <= 5'd0;
    end else begin
      result_valid <= 1'b0;
      case (state)
        IDLE: if (dec_md) begin
          state <= BUSY;
          cnt <= 6'd0;
          p <= {32'd0, dec_div ? mag(data_in_A) : mag(data_in_B)};
          mc <= dec_div ? mag(data_in_B) : mag(data_in_A);
          rd <= in_IR[26:22];
          is_div <= dec_div;
          neg <= data_in_A[31] ^ data_in_B[31];
          b_zero <= data_in_B == 32'd0;
        end
        BUSY: begin
          p <= p_nxt;
          cnt <= cnt + 6'd1;
          if (last) begin
            state <= DONE;
            result <= fin_res;
            exception <= fin_exc;
            result_rd <= rd;
            result_valid <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_x_multdiv.sv
// tb_x_multdiv: directed and randomized checks of x_multdiv against a plain-arithmetic reference model.
module tb_x_multdiv;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [31:0] in_IR = 32'd0, data_in_A = 32'd0, data_in_B = 32'd0;
  logic stall, result_valid, exception;
  logic [31:0] result;
  logic [4:0] result_rd;
  int n_cmp = 0, n_bad = 0, gc = 0, last_pulse = 0;
`ifdef X_MULTDIV_DIVZERO_FAST_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif
  x_multdiv dut (
    .clk(clk), .reset(reset), .in_IR(in_IR), .data_in_A(data_in_A), .data_in_B(data_in_B),
    .stall(stall), .result(result), .result_valid(result_valid), .exception(exception), .result_rd(result_rd)
  );
  always #5 clk = ~clk;
  always @(posedge clk) gc++;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] md_ir(input bit div, input logic [4:0] rd);
    logic [14:0] junk;
    junk = 15'($urandom);
    return {5'd0, rd, junk, div ? 5'b00111 : 5'b00110, 2'b00};
  endfunction
  function automatic logic [32:0] ref_md(input bit div, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] pr;
    logic signed [31:0] q;
    if (!div) begin
      pr = {{32{a[31]}}, a} * {{32{b[31]}}, b};
      return {pr[63:32] != {32{pr[31]}}, pr[31:0]};
    end
    if (b == 32'd0) return {1'b1, 32'd0};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b1, a};
    q = $signed(a) / $signed(b);
    return {1'b0, q};
  endfunction
  task automatic run_op(input string tag, input bit div, input logic [4:0] rd,
                        input logic [31:0] a, input logic [31:0] b, input logic [32:0] exp);
    int cyc = 1;
    int stalls = 0;
    bit got = 1'b0;
    int lat = (FAST && div && b == 32'd0) ? 3 : 34;
    @(negedge clk);
    reset = 1'b1;
    in_IR = md_ir(div, rd);
    data_in_A = a;
    data_in_B = b;
    while (cyc <= 40) begin
      #1;
      if (result_valid) begin
        got = 1'b1;
        break;
      end
      if (stall) stalls++;
      if (cyc == 5) begin
        data_in_A = $urandom;
        data_in_B = $urandom;
      end
      @(negedge clk);
      cyc++;
    end
    last_pulse = gc;
    chk({tag, ".lat"}, 64'(got ? cyc : 0), 64'(lat));
    chk({tag, ".stalls"}, 64'(stalls), 64'(lat - 1));
    if (got) begin
      chk({tag, ".result"}, 64'(result), 64'(exp[31:0]));
      chk({tag, ".exc"}, 64'(exception), 64'(exp[32]));
      chk({tag, ".rd"}, 64'(result_rd), 64'(rd));
      chk({tag, ".stall_done"}, 64'(stall), 64'd0);
    end
  endtask
  task automatic idle(input int n);
    @(negedge clk);
    in_IR = 32'd0;
    repeat (n) @(negedge clk);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int p1;
    bit any_s, any_v, dv;
    logic [31:0] a, b, ir;
    in_IR = md_ir(1'b0, 5'd3);
    data_in_A = 32'd5;
    data_in_B = 32'd6;
    repeat (2) @(negedge clk);
    #1;
    chk("rst.stall", 64'(stall), 64'd0);
    chk("rst.valid", 64'(result_valid), 64'd0);
    chk("rst.result", 64'(result), 64'd0);
    chk("rst.exc", 64'(exception), 64'd0);
    chk("rst.rd", 64'(result_rd), 64'd0);
    run_op("mul_7x-6", 1'b0, 5'd5, 32'd7, 32'hFFFF_FFFA, {1'b0, 32'hFFFF_FFD6});
    idle(2);
    run_op("mul_ovf", 1'b0, 5'd7, 32'h0001_0000, 32'h0001_0000, {1'b1, 32'd0});
    run_op("div_-7/2", 1'b1, 5'd9, 32'hFFFF_FFF9, 32'd2, {1'b0, 32'hFFFF_FFFD});
    run_op("div_min/-1", 1'b1, 5'd10, 32'h8000_0000, 32'hFFFF_FFFF, {1'b1, 32'h8000_0000});
    run_op("div_5/0", 1'b1, 5'd11, 32'd5, 32'd0, {1'b1, 32'd0});
    idle(1);
    run_op("b2b_mul", 1'b0, 5'd1, 32'd2, 32'd3, {1'b0, 32'd6});
    p1 = last_pulse;
    run_op("b2b_div", 1'b1, 5'd2, 32'd9, 32'd4, {1'b0, 32'd2});
    chk("b2b.gap", 64'(last_pulse - p1), 64'd34);
    idle(3);
    @(negedge clk);
    in_IR = md_ir(1'b0, 5'd4);
    data_in_A = 32'd100;
    data_in_B = 32'hFFFF_FFFD;
    repeat (10) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("abort.valid0", 64'(result_valid), 64'd0);
    chk("abort.stall", 64'(stall), 64'd0);
    chk("abort.result", 64'(result), 64'd0);
    chk("abort.rd", 64'(result_rd), 64'd0);
    @(negedge clk);
    #1;
    chk("abort.valid1", 64'(result_valid), 64'd0);
    run_op("abort_restart", 1'b0, 5'd4, 32'd100, 32'hFFFF_FFFD, {1'b0, 32'hFFFF_FED4});
    any_s = 1'b0;
    any_v = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 60; i++) begin
      ir = $urandom;
      if (ir[31:27] == 5'd0 && ir[6:3] == 4'b0011) ir[31] = 1'b1;
      in_IR = (i < 30) ? 32'd0 : ir;
      #1;
      any_s |= stall;
      any_v |= result_valid;
      @(negedge clk);
    end
    chk("nonmd.stall", 64'(any_s), 64'd0);
    chk("nonmd.valid", 64'(any_v), 64'd0);
    for (int i = 0; i < 40; i++) begin
      dv = 1'b1 & $urandom_range(0, 1);
      a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) - 32'd20 : $urandom;
      if ($urandom_range(0, 9) == 0) a = 32'h8000_0000;
      b = ($urandom_range(0, 5) == 0) ? 32'd0 :
          ($urandom_range(0, 4) == 0) ? 32'($urandom_range(0, 16)) - 32'd8 : $urandom;
      run_op($sformatf("rnd%0d", i), dv, 5'($urandom), a, b, ref_md(dv, a, b));
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/x_multdiv.md
X_MULTDIV -- requirements
Module: x_multdiv

Interface
REQ-001 The block SHALL expose these ports:
- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous active-low reset (0 = reset)
- in_IR  in  32  instruction from D/X register
- data_in_A  in  32  operand rs from D/X register
- data_in_B  in  32  operand rt from D/X register
- stall  out  1  freeze PC, F/D and D/X registers this cycle
- result  out  32  mul/div result
- result_valid  out  1  result and exception are valid this cycle
- exception  out  1  overflow or divide-by-zero for the completed op
- result_rd  out  5  destination register of the completed op
REQ-002 Clock and reset SHALL be exactly as stated above: one clock, asynchronous active-low reset.

Function
REQ-003 Decode SHALL treat in_IR as mul when in_IR[31:27]=00000 and in_IR[6:2]=00110, and as div when in_IR[31:27]=00000 and in_IR[6:2]=00111; all other encodings are non-md.
REQ-004 The FSM SHALL have exactly three states: IDLE, BUSY and DONE.
REQ-005 In IDLE with an md instruction, the next edge SHALL latch A, B, op type and in_IR[26:22], clear a 6-bit counter, and enter BUSY.
REQ-006 BUSY SHALL perform one iteration per cycle (mul: radix-2 shift-add on magnitudes; div: restoring on magnitudes) and enter DONE after exactly 32 BUSY cycles.
REQ-007 DONE SHALL last exactly one cycle and return to IDLE unconditionally.
REQ-008 stall SHALL be combinational: 1 when an md instruction is decoded and state is not DONE; otherwise 0.
REQ-009 result_valid SHALL be 1 only in DONE, and result, exception and result_rd SHALL be stable for that cycle.
REQ-010 Latency: an md op SHALL hold stall for 33 cycles (1 IDLE + 32 BUSY), and result_valid SHALL assert on the 34th cycle.
REQ-011 Signs SHALL be handled by operating on absolute values and negating the result when the operand signs differ.
REQ-012 Division SHALL truncate toward zero.
REQ-013 mul: result SHALL equal the low 32 bits of the signed 64-bit product, and exception SHALL be 1 when the product is not the sign-extension of those bits.
REQ-014 div by zero: result SHALL be 0 and exception SHALL be 1.
REQ-015 div 0x80000000 / -1: result SHALL be 0x80000000 and exception SHALL be 1.
REQ-016 Back-to-back: an md instruction present in IDLE directly after DONE SHALL start a new op with no bubble beyond REQ-010.
REQ-017 The same instruction still held in D/X during DONE SHALL NOT restart, because DONE always exits to IDLE.
REQ-018 Operand changes on data_in_A/data_in_B during BUSY SHALL be ignored; only the values latched in IDLE are used.
REQ-019 Non-md instructions SHALL never assert stall or result_valid.

Reset
REQ-020 While reset=0 the block SHALL force state=IDLE, counter=0, all internal datapath registers=0, and stall qualified low, with result=0, result_valid=0, exception=0 and result_rd=0.
REQ-021 Assertion of reset in BUSY SHALL abandon the op with no result_valid pulse; after release, a still-present md instruction SHALL restart from IDLE.

Configuration
REQ-022 With macro X_MULTDIV_DIVZERO_FAST_EN defined, a div whose latched B=0 SHALL go from BUSY directly to DONE after one BUSY cycle, giving 2 stall cycles and result_valid on cycle 3.
REQ-023 Without X_MULTDIV_DIVZERO_FAST_EN, divide-by-zero SHALL take the full latency of REQ-010; results per REQ-014 are identical in both builds.

Verification
REQ-024 mul A=7, B=-6, rd=5 -> stall for 33 cycles; then result=0xFFFFFFD6 (-42), exception=0, result_rd=5 for one cycle.
REQ-025 mul A=0x00010000, B=0x00010000 -> result=0x00000000, exception=1.
REQ-026 div A=-7, B=2 -> result=0xFFFFFFFD (-3), exception=0; div A=0x80000000, B=-1 -> result=0x80000000, exception=1.
REQ-027 div A=5, B=0 -> result=0, exception=1; the bench SHALL check latency 34 cycles without the macro and 3 cycles with X_MULTDIV_DIVZERO_FAST_EN.
REQ-028 mul followed immediately by div (2,3 then 9,4) -> two result_valid pulses (6 then 2), 34 cycles apart, with no duplicate pulse.
REQ-029 reset=0 at BUSY cycle 10, released 2 cycles later, with mul held in D/X -> no result_valid during reset; full 34-cycle sequence then restarts; add instruction -> stall=0 throughout.
